// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned N-bit restoring divider (one quotient bit per clock).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse; accepted in IDLE or DONE, ignored while RUN
//   dividend     unsigned dividend, sampled with an accepted start
//   divisor      unsigned divisor, sampled with an accepted start
//   busy         high while a division is iterating
//   done         one-cycle pulse; quotient/remainder/div_by_zero updated this cycle
//   quotient     quotient of the last completed operation
//   remainder    remainder of the last completed operation
//   div_by_zero  last completed operation had a zero divisor
module restoring_divider #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  q, q_nxt;
    // After every restore R < D, so the top bit of the N+1-bit working
    // remainder is always zero between iterations; only N bits are stored.
    logic [N-1:0]  r, r_nxt;
    logic [N-1:0]  d, d_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  quo_nxt, rem_nxt;
    logic          dbz_nxt;
    logic          busy_nxt, done_nxt;
    logic [N:0]    r_sh;
    logic [N:0]    trial;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            q           <= q_nxt;
            r           <= r_nxt;
            d           <= d_nxt;
            cnt         <= cnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    // Next-state, iteration and result logic.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        r_nxt     = r;
        d_nxt     = d;
        cnt_nxt   = cnt;
        quo_nxt   = quotient;
        rem_nxt   = remainder;
        dbz_nxt   = div_by_zero;

        // Shift the next dividend bit into R, then trial-subtract D.
        r_sh  = {r, q[N-1]};
        trial = r_sh - {1'b0, d};

        unique case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    state_nxt = IDLE;
                end
                if (start) begin
                    q_nxt   = dividend;
                    r_nxt   = '0;
                    d_nxt   = divisor;
                    cnt_nxt = CW'(N);
                    if (divisor == '0) begin
                        state_nxt = DONE;
                        quo_nxt   = '1;
                        rem_nxt   = dividend;
                        dbz_nxt   = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                // A negative trial (borrow in bit N) restores the shifted R.
                r_nxt   = trial[N] ? r_sh[N-1:0] : trial[N-1:0];
                q_nxt   = {q[N-2:0], ~trial[N]};
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                    quo_nxt   = q_nxt;
                    rem_nxt   = r_nxt;
                    dbz_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: scoreboard bench for restoring_divider at N=4 and N=8.
module tb_restoring_divider;

    typedef struct {
        logic [31:0] dd;
        logic [31:0] dv;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] z;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       st4, st8;
    logic [3:0] dd4, dv4;
    logic [7:0] dd8, dv8;
    logic       busy4, done4, dbz4;
    logic [3:0] quo4, rem4;
    logic       busy8, done8, dbz8;
    logic [7:0] quo8, rem8;

    exp_t sb4[$];
    exp_t sb8[$];
    int   total = 0;
    int   bad   = 0;

    restoring_divider #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .dividend(dd4), .divisor(dv4),
        .busy(busy4), .done(done4), .quotient(quo4), .remainder(rem4), .div_by_zero(dbz4)
    );

    restoring_divider #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .dividend(dd8), .divisor(dv8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, all-ones quotient for a zero divisor.
    function automatic exp_t model(input int w, input int a, input int b);
        exp_t e;
        e.dd = 32'(a);
        e.dv = 32'(b);
        if (b == 0) begin
            e.q = (32'd1 << w) - 32'd1;
            e.r = 32'(a);
            e.z = 32'd1;
        end else begin
            e.q = 32'(a / b);
            e.r = 32'(a % b);
            e.z = 32'd0;
        end
        return e;
    endfunction

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done4) begin
            exp_t e;
            chk("busy_with_done4", 32'(busy4), 32'd0);
            if (sb4.size() == 0) begin
                chk("unexpected_done4", 32'd1, 32'd0);
            end else begin
                e = sb4.pop_front();
                chk("quotient4", 32'(quo4), e.q);
                chk("remainder4", 32'(rem4), e.r);
                chk("div_by_zero4", 32'(dbz4), e.z);
                if (e.dv != 0) begin
                    chk("identity4", 32'(quo4) * e.dv + 32'(rem4), e.dd);
                    chk("rem_lt_div4", 32'(32'(rem4) < e.dv), 32'd1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            exp_t e;
            chk("busy_with_done8", 32'(busy8), 32'd0);
            if (sb8.size() == 0) begin
                chk("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = sb8.pop_front();
                chk("quotient8", 32'(quo8), e.q);
                chk("remainder8", 32'(rem8), e.r);
                chk("div_by_zero8", 32'(dbz8), e.z);
                if (e.dv != 0) begin
                    chk("identity8", 32'(quo8) * e.dv + 32'(rem8), e.dd);
                    chk("rem_lt_div8", 32'(32'(rem8) < e.dv), 32'd1);
                end
            end
        end
    end

    // Present one accepted start (called just after a falling edge).
    task automatic issue4(input int a, input int b);
        dd4 = 4'(a);
        dv4 = 4'(b);
        st4 = 1'b1;
        sb4.push_back(model(4, a, b));
        @(posedge clk);
        #1 st4 = 1'b0;
    endtask

    task automatic issue8(input int a, input int b);
        dd8 = 8'(a);
        dv8 = 8'(b);
        st8 = 1'b1;
        sb8.push_back(model(8, a, b));
        @(posedge clk);
        #1 st8 = 1'b0;
    endtask

    // Wait (bounded) for done; m0 = cycles already elapsed since the start edge.
    task automatic wait4(input int m0, input int exp_lat, input int exp_busy, input string name);
        int m  = m0;
        int bc = 0;
        bit seen = 1'b0;
        while (!seen && m < m0 + 40) begin
            @(negedge clk);
            m++;
            if (done4) seen = 1'b1;
            else if (busy4) bc++;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(m), 32'(exp_lat));
        chk({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    endtask

    task automatic wait8(input int exp_lat, input string name);
        int m = 0;
        bit seen = 1'b0;
        while (!seen && m < 40) begin
            @(negedge clk);
            m++;
            if (done8) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(m), 32'(exp_lat));
    endtask

    initial begin
        int nd;
        int mul;
        int off;
        rst_n = 1'b0;
        st4 = 1'b0; dd4 = '0; dv4 = '0;
        st8 = 1'b0; dd8 = '0; dv8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy4), 32'd0);
        chk("reset_done", 32'(done4), 32'd0);
        chk("reset_quotient", 32'(quo4), 32'd0);
        chk("reset_remainder", 32'(rem4), 32'd0);
        chk("reset_dbz", 32'(dbz4), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Directed N=4 cases.
        issue4(13, 3);  wait4(0, 5, 4, "d13_3");
        issue4(15, 1);  wait4(0, 5, 4, "d15_1");
        issue4(3, 7);   wait4(0, 5, 4, "d3_7");
        issue4(15, 15); wait4(0, 5, 4, "d15_15");
        issue4(0, 5);   wait4(0, 5, 4, "d0_5");
        repeat (2) @(negedge clk);
        issue4(5, 0);   wait4(0, 1, 0, "d5_0");
        issue4(9, 2);   wait4(0, 5, 4, "d9_2");
        repeat (2) @(negedge clk);

        // A start during RUN must be ignored; then back-to-back from DONE.
        issue4(14, 4);
        @(negedge clk);
        dd4 = 4'd1; dv4 = 4'd1; st4 = 1'b1;
        @(posedge clk);
        #1 st4 = 1'b0;
        wait4(1, 5, 3, "ignore");
        issue4(7, 2);   wait4(0, 5, 4, "b2b");
        repeat (3) @(negedge clk);

        // Reset in the middle of RUN.
        issue4(11, 2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_done", 32'(done4), 32'd0);
        chk("abort_quotient", 32'(quo4), 32'd0);
        chk("abort_remainder", 32'(rem4), 32'd0);
        chk("abort_dbz", 32'(dbz4), 32'd0);
        sb4.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done4) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        issue4(11, 2);  wait4(0, 5, 4, "after_abort");

        // All 256 N=4 pairs in a random order with random idle gaps.
        mul = int'($urandom_range(0, 127)) * 2 + 1;
        off = int'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            int p = (i * mul + off) & 255;
            int a = p >> 4;
            int b = p & 15;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue4(a, b);
            wait4(0, (b == 0) ? 1 : 5, (b == 0) ? 0 : 4, "sweep4");
        end

        // Random N=8 operations, including boundary operands.
        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            if (i == 0) begin a = 255; b = 1; end
            if (i == 1) begin a = 254; b = 255; end
            if (i == 2) begin a = 255; b = 255; end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue8(a, b);
            wait8((b == 0) ? 1 : 9, "sweep8");
        end

        repeat (5) @(negedge clk);
        chk("sb4_drained", 32'(sb4.size()), 32'd0);
        chk("sb8_drained", 32'(sb8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Multi-cycle unsigned N-bit restoring divider for the ULA datapath. It performs the inverse of the adder chain by iterating trial subtractions, one quotient bit per clock. Operands are accepted on a single-cycle start handshake. Quotient and remainder are returned with a one-cycle done pulse and a divide-by-zero flag. The block sits beside the adder and subtractor units as the ULA's division path.

## Interface
- N, 4: operand, quotient and remainder width in bits (N >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled on rising clk edge
- dividend  input  N  unsigned dividend, sampled with accepted start
- divisor  input  N  unsigned divisor, sampled with accepted start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse: results updated this cycle
- quotient  output  N  registered quotient of last completed operation
- remainder  output  N  registered remainder of last completed operation
- div_by_zero  output  1  registered flag: last completed operation had divisor == 0

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous) clears every register immediately:
  - state = IDLE; busy = 0; done = 0.
  - quotient = 0; remainder = 0; div_by_zero = 0; iteration counter = 0.
- Accepting a start:
  - start is accepted only in IDLE or DONE. start in RUN is ignored and has no effect on the operation in progress.
  - On acceptance: dividend loads the working quotient register Q; working remainder R (N+1 bits) is cleared; divisor is latched into D; counter = N.
  - If the divisor is nonzero, go to RUN.
  - If the divisor is zero, go straight to DONE with quotient = all ones (2^N-1), remainder = dividend, div_by_zero = 1.
- RUN, one iteration per cycle:
  - Shift: R = {R[N-1:0], Q[N-1]}; Q = {Q[N-2:0], 0}.
  - Trial: T = R - {0,D}, computed N+1 bits wide.
  - If T[N] == 0, set R = T and Q[0] = 1. Otherwise R is restored, i.e. kept unchanged.
  - Decrement the counter. After the iteration where the counter reaches 0, go to DONE.
- Entering DONE from RUN: quotient = Q, remainder = R[N-1:0], div_by_zero = 0.
- DONE lasts one cycle; done = 1 in this cycle.
  - If start is high in DONE, the new operation is accepted and the next state is RUN, or DONE for a zero divisor.
  - Otherwise the next state is IDLE.
- quotient, remainder and div_by_zero change only on entry to DONE. They hold through IDLE and through the next RUN.
- Arithmetic: unsigned only. Remainder < divisor always holds for a nonzero divisor, and quotient*divisor + remainder == dividend.

## Timing
- Accepted start at edge k:
  - Nonzero divisor: busy = 1 for cycles k+1 .. k+N; done = 1 in cycle k+N+1 (after edge k+N). Latency is N+1 cycles from start to done.
  - Zero divisor: done = 1 in cycle k+1; busy stays 0.
- busy and done are registered outputs decoded from state, and are never high together.
- Back-to-back: a start accepted in the DONE cycle begins the next operation with no idle bubble. Throughput is one result per N+1 cycles.
- Reset mid-RUN aborts the operation. No done pulse follows, and the outputs return to their reset values immediately.
- rst_n deassertion is synchronous to clk at the system level. The first start is accepted on the first edge after release.

## Test plan
- N=4: dividend 13, divisor 3, start at edge k.
  - Required: busy 4 cycles, done at cycle k+5, quotient 4, remainder 1, div_by_zero 0.
- N=4, edge cases:
  - 15/1 -> quotient 15, remainder 0.
  - 3/7 -> quotient 0, remainder 3.
  - 15/15 -> quotient 1, remainder 0.
  - 0/5 -> quotient 0, remainder 0.
- N=4: dividend 5, divisor 0.
  - Required: done at cycle k+1, busy never high, quotient 15, remainder 5, div_by_zero 1.
  - The next 9/2 operation clears div_by_zero and returns 4 r 1.
- Start 14/4, then pulse start with 1/1 during RUN.
  - Required: second start ignored; result 3 r 2 with a single done pulse.
  - Sequencing: 14/4 completes; raise start with 7/2 in the done cycle.
  - Required: next done exactly 5 cycles later with 3 r 1.
- Start 11/2, drop rst_n for half a cycle during RUN.
  - Required: busy, done, quotient, remainder and div_by_zero all 0 immediately, no later done pulse.
  - A subsequent 11/2 returns 5 r 1.
- Randomized N=4 and N=8 sweeps (all 256 pairs for N=4) against a reference model.
  - Required: quotient*divisor + remainder == dividend and remainder < divisor for every nonzero divisor.
  - Required: exactly one done pulse per accepted start.
